icache_direct: RTL and testbench
================================

Name: icache_direct

Overview:
- Read-only, direct-mapped instruction cache.
- Sits between the core's instruction-fetch port (icache_addr/icache_req/icache_data/icache_rdy) and the instruction memory bus.
- Serves hits from an internal line array and handles misses by refilling one full line, word by word, from memory.
- Provides a flush input for fence.i-style invalidation.

Parameters:
- LINES, 64, number of cache lines; power of two, >= 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, >= 2.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- icache_addr  input  32  fetch byte address from core; bits [1:0] ignored.
- icache_req  input  1  fetch request; core holds it and icache_addr stable until icache_rdy.
- icache_data  output  32  fetched instruction word; valid only while icache_rdy=1.
- icache_rdy  output  1  one-cycle completion pulse.
- flush  input  1  invalidate all lines.
- mem_addr  output  32  word-aligned refill address.
- mem_req  output  1  refill word request; held with mem_addr until mem_rdy.
- mem_rdata  input  32  refill data; valid when mem_rdy=1.
- mem_rdy  input  1  memory word-accept/return pulse.

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE)+2, IDX = log2(LINES).
  - word = addr[OFF-1:2]; index = addr[OFF+IDX-1:OFF]; tag = addr[31:OFF+IDX].
- Storage: per line a valid bit, a tag, and WORDS_PER_LINE data words. Data and tag arrays are not reset; valid bits are.
- Reset (reset=0 at an edge):
  - State goes to IDLE and all valid bits clear.
  - icache_rdy=0, icache_data=0, mem_req=0, mem_addr=0.
  - Reset mid-fill abandons the fill and installs nothing.
- States: IDLE, LOOKUP, FILL, RESPOND.
- IDLE:
  - If icache_req=1, latch icache_addr into req_addr and go to LOOKUP.
  - Otherwise stay in IDLE.
- LOOKUP:
  - Hit when valid[index]=1 and tag matches.
  - Hit: assert icache_rdy=1 for this cycle with icache_data set to the stored word, then go to IDLE.
  - Miss: clear the counter cnt, clear valid[index], go to FILL.
  - Hit latency is 1 cycle after the req sample edge. Back-to-back hits complete every 2 cycles.
- FILL:
  - mem_req=1; mem_addr = {req_addr tag, index, cnt, 2'b00}.
  - On mem_rdy=1: write mem_rdata into word cnt of the line, then cnt+1.
  - On the last word (cnt = WORDS_PER_LINE-1, mem_rdy=1): write tag, set valid, go to RESPOND.
  - Refill order is always word 0 upward; there is no critical-word-first.
  - mem_req/mem_addr stay stable while mem_rdy=0; unlimited stall is allowed.
- RESPOND:
  - icache_rdy=1 and icache_data = requested word of the newly filled line, then go to IDLE.
  - Miss latency = 1 (LOOKUP) + refill cycles + 1.
- icache_rdy is never high outside LOOKUP-hit or RESPOND, and is always exactly 1 cycle.
- Request withdrawal: if the core drops icache_req after it was latched, the cache still completes the lookup/fill and pulses icache_rdy. The core ignores that pulse.
- flush:
  - In IDLE with flush=1: clear all valid bits that cycle. The flush takes priority, so a concurrent icache_req is not latched that cycle and is accepted in the following cycle.
  - In any other state: record a pending flush and apply it on the first IDLE cycle, before accepting a new request. The in-flight response still completes normally.
  - A flush arriving while a flush is already pending collapses into one flush.
- Address wrap: a line at 0xFFFFFFF0 (defaults) fills 0xFFFFFFF0..0xFFFFFFFC. cnt never carries into the index.
- Aliasing: a miss evicts whatever line occupies the index; there is no write-back (read-only).

Test Plan:
1. Reset, then request 0x00000104 with mem returning 0xA0+k for word k, mem_rdy every cycle:
   - mem_addr sequence is 0x100, 0x104, 0x108, 0x10C.
   - RESPOND gives icache_data=0xA1.
   - A second request to 0x10C hits one cycle after its sample edge with 0xA3 and no mem_req.
2. Conflict eviction (defaults): after filling 0x100, request 0x00000500 (same index 0x10, different tag):
   - A refill occurs.
   - Re-requesting 0x104 misses again.
3. Memory stall, mem_rdy low for 5 cycles per word:
   - mem_req and mem_addr are held constant through the stall.
   - icache_rdy stays 0 until RESPOND.
   - Total miss latency = 1 + 24 + 1 cycles.
4. Flush:
   - Flush during FILL of 0x200: the request still completes with correct data, then all lines are invalidated.
   - A re-request of 0x200 misses.
   - Flush with icache_req in the same IDLE cycle: the request is accepted the next cycle and misses.
5. Reset asserted mid-FILL after 2 of 4 words: mem_req=0 the next cycle, and request 0x300 afterward refills from word 0.
6. Req withdrawn during fill of 0x400:
   - The fill completes and icache_rdy pulses once.
   - A later 0x404 request hits.

Source files
------------

// File: rtl/icache_direct_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_direct_if
// Brief    : Fetch-port and refill-bus signal bundle for icache_direct.
// Revision : 1.0 - initial release
// ============================================================================
interface icache_direct_if;
    logic [31:0] icache_addr;
    logic        icache_req;
    logic [31:0] icache_data;
    logic        icache_rdy;
    logic        flush;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic [31:0] mem_rdata;
    logic        mem_rdy;

    // master: core + instruction memory side; slave: the cache itself
    modport master (
        output icache_addr, icache_req, flush, mem_rdata, mem_rdy,
        input  icache_data, icache_rdy, mem_addr, mem_req
    );
    modport slave (
        input  icache_addr, icache_req, flush, mem_rdata, mem_rdy,
        output icache_data, icache_rdy, mem_addr, mem_req
    );
endinterface
`default_nettype wire

// File: rtl/icache_direct.sv
`default_nettype none
// ============================================================================
// Module   : icache_direct
// Brief    : Read-only direct-mapped instruction cache with line refill.
// Revision : 1.0 - initial release
// ============================================================================
module icache_direct #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  wire            clock,
    input  wire            reset,
    icache_direct_if.slave bus
);
    localparam int c_WB  = $clog2(WORDS_PER_LINE);
    localparam int c_IDX = $clog2(LINES);
    localparam int c_OFF = c_WB + 2;
    localparam int c_TAG = 32 - c_OFF - c_IDX;

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_LOOKUP  = 2'd1;
    localparam logic [1:0] c_ST_FILL    = 2'd2;
    localparam logic [1:0] c_ST_RESPOND = 2'd3;

    localparam logic [c_WB-1:0] c_LAST = c_WB'(WORDS_PER_LINE - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [31:0]       r_req_addr;
    logic [c_WB-1:0]   r_cnt;
    logic [LINES-1:0]  r_valid;
    logic              r_flush_pend;
    logic [c_TAG-1:0]  r_tag  [LINES];
    logic [31:0]       r_data [LINES*WORDS_PER_LINE];

    logic [c_WB-1:0]   w_word;
    logic [c_IDX-1:0]  w_idx;
    logic [c_TAG-1:0]  w_tag;
    logic              w_hit;
    logic              w_fill_last;
    logic              w_do_flush;
    logic [31:0]       w_rd_word;
    logic              w_rdy;
    logic [31:0]       w_data;
    logic              w_mreq;
    logic [31:0]       w_maddr;
    logic              w_unused;

    assign w_word      = r_req_addr[c_OFF-1:2];
    assign w_idx       = r_req_addr[c_OFF+c_IDX-1:c_OFF];
    assign w_tag       = r_req_addr[31:c_OFF+c_IDX];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_rd_word   = r_data[{w_idx, w_word}];
    assign w_fill_last = bus.mem_rdy && (r_cnt == c_LAST);
    assign w_do_flush  = bus.flush || r_flush_pend;
    assign w_unused    = ^r_req_addr[1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_rdy       = 1'b0;
        w_data      = '0;
        w_mreq      = 1'b0;
        w_maddr     = '0;
        case (r_state)
            c_ST_IDLE: begin
                // a flush (new or pending) owns this IDLE cycle; the request waits
                if (!w_do_flush && bus.icache_req) begin
                    w_state_nxt = c_ST_LOOKUP;
                end
            end
            c_ST_LOOKUP: begin
                if (w_hit) begin
                    w_rdy       = 1'b1;
                    w_data      = w_rd_word;
                    w_state_nxt = c_ST_IDLE;
                end else begin
                    w_state_nxt = c_ST_FILL;
                end
            end
            c_ST_FILL: begin
                w_mreq  = 1'b1;
                w_maddr = {w_tag, w_idx, r_cnt, 2'b00};
                if (w_fill_last) begin
                    w_state_nxt = c_ST_RESPOND;
                end
            end
            c_ST_RESPOND: begin
                w_rdy       = 1'b1;
                w_data      = w_rd_word;
                w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
            r_cnt        <= '0;
            r_req_addr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_ST_IDLE) begin
                if (w_do_flush) begin
                    r_valid      <= '0;
                    r_flush_pend <= 1'b0;
                end else if (bus.icache_req) begin
                    r_req_addr <= bus.icache_addr;
                end
            end else if (bus.flush) begin
                r_flush_pend <= 1'b1;
            end
            if (r_state == c_ST_LOOKUP && !w_hit) begin
                r_cnt          <= '0;
                r_valid[w_idx] <= 1'b0;
            end
            if (r_state == c_ST_FILL && bus.mem_rdy) begin
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == c_LAST) begin
                    r_valid[w_idx] <= 1'b1;
                end
            end
        end
    end

    // Line storage carries no reset; the valid bits alone qualify it.
    always_ff @(posedge clock) begin
        if (reset && r_state == c_ST_FILL && bus.mem_rdy) begin
            r_data[{w_idx, r_cnt}] <= bus.mem_rdata;
            if (r_cnt == c_LAST) begin
                r_tag[w_idx] <= w_tag;
            end
        end
    end

    assign bus.icache_rdy  = w_rdy;
    assign bus.icache_data = w_data;
    assign bus.mem_req     = w_mreq;
    assign bus.mem_addr    = w_maddr;
endmodule
`default_nettype wire

// File: tb/tb_icache_direct.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_direct
// Brief    : Self-checking bench for icache_direct (default geometry).
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_direct;
    logic clock;
    logic reset;
    int   cyc;
    int   total;
    int   bad;
    int   mem_stall;

    icache_direct_if bus ();

    icache_direct #(
        .LINES          (64),
        .WORDS_PER_LINE (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          stall;
        bit          hit;
        logic [31:0] data;
        int          dly;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] mem_q[$];
    vec_t        vecs[12];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] line;
        line = {4'h0, a[31:4]};
        return 32'hA0 + {30'h0, a[3:2]} + ((line - 32'h10) << 8);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // memory model: answers each word after mem_stall idle cycles
    initial begin
        int          wait_cnt;
        logic        prev_req;
        logic        prev_rdy;
        logic [31:0] prev_addr;
        logic [31:0] exp_a;
        wait_cnt = 0;
        prev_req = 1'b0;
        prev_rdy = 1'b0;
        prev_addr = '0;
        bus.mem_rdy = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clock);
            #1;
            if (reset === 1'b1 && prev_req === 1'b1 && prev_rdy === 1'b0) begin
                check("mem_req_hold", {31'h0, bus.mem_req}, 32'h1);
                check("mem_addr_hold", bus.mem_addr, prev_addr);
            end
            if (bus.mem_rdy) begin
                bus.mem_rdy = 1'b0;
                wait_cnt = 0;
            end
            if (bus.mem_req === 1'b1) begin
                if (wait_cnt >= mem_stall) begin
                    bus.mem_rdy = 1'b1;
                    bus.mem_rdata = mem_word(bus.mem_addr);
                    if (mem_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL mem_unexpected: got mem_addr %h expected no refill", bus.mem_addr);
                    end else begin
                        exp_a = mem_q.pop_front();
                        check("mem_addr_seq", bus.mem_addr, exp_a);
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
            prev_req = bus.mem_req;
            prev_rdy = bus.mem_rdy;
            prev_addr = bus.mem_addr;
        end
    end

    // completion monitor: every icache_rdy pulse must match the scoreboard head
    initial begin
        sb_t e;
        forever begin
            @(posedge clock);
            #1;
            if (bus.icache_rdy === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_rdy: got icache_rdy=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check("rdy_data", bus.icache_data, e.data);
                    check("rdy_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic do_req(input logic [31:0] addr, input int stall, input bit hit,
                          input logic [31:0] data, input int dly, input bit withdraw);
        sb_t         e;
        bit          seen;
        logic [31:0] base;
        seen = 1'b0;
        mem_stall = stall;
        e.data = data;
        e.cyc = cyc + 1 + dly + (hit ? 0 : 1 + 4 * (stall + 1));
        sb.push_back(e);
        base = {addr[31:4], 4'h0};
        if (!hit) begin
            for (int k = 0; k < 4; k++) mem_q.push_back(base + 32'(k * 4));
        end
        bus.icache_addr = addr;
        bus.icache_req = 1'b1;
        for (int i = 1; i <= 200 && !seen; i++) begin
            @(posedge clock);
            #1;
            if (withdraw && i == 2) bus.icache_req = 1'b0;
            if (bus.icache_rdy === 1'b1) seen = 1'b1;
        end
        bus.icache_req = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL req_timeout: got no icache_rdy for %h expected one within 200 cycles", addr);
            sb.delete();
            mem_q.delete();
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish by 400000");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{32'h0000_0104, 0, 1'b0, 32'h0000_00A1, 0};
        vecs[1]  = '{32'h0000_010C, 0, 1'b1, 32'h0000_00A3, 1};
        vecs[2]  = '{32'h0000_0500, 0, 1'b0, mem_word(32'h500), 1};
        vecs[3]  = '{32'h0000_0104, 0, 1'b0, 32'h0000_00A1, 1};
        vecs[4]  = '{32'h0000_0108, 0, 1'b1, 32'h0000_00A2, 1};
        vecs[5]  = '{32'h0000_0600, 5, 1'b0, mem_word(32'h600), 1};
        vecs[6]  = '{32'h0000_0604, 0, 1'b1, mem_word(32'h604), 1};
        vecs[7]  = '{32'hFFFF_FFF4, 0, 1'b0, mem_word(32'hFFFF_FFF4), 1};
        vecs[8]  = '{32'hFFFF_FFFC, 0, 1'b1, mem_word(32'hFFFF_FFFC), 1};
        vecs[9]  = '{32'h0000_0000, 0, 1'b0, mem_word(32'h0), 1};
        vecs[10] = '{32'h0000_0008, 0, 1'b1, mem_word(32'h8), 1};
        vecs[11] = '{32'h0000_0100, 0, 1'b1, 32'h0000_00A0, 1};

        cyc = 0;
        total = 0;
        bad = 0;
        mem_stall = 0;
        reset = 1'b0;
        bus.icache_addr = '0;
        bus.icache_req = 1'b0;
        bus.flush = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset_icache_rdy", {31'h0, bus.icache_rdy}, 32'h0);
        check("reset_icache_data", bus.icache_data, 32'h0);
        check("reset_mem_req", {31'h0, bus.mem_req}, 32'h0);
        check("reset_mem_addr", bus.mem_addr, 32'h0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        foreach (vecs[i]) begin
            do_req(vecs[i].addr, vecs[i].stall, vecs[i].hit, vecs[i].data, vecs[i].dly, 1'b0);
        end

        // flush during the fill of 0x200: response still good, then everything invalid
        fork
            do_req(32'h200, 0, 1'b0, mem_word(32'h200), 1, 1'b0);
            begin
                repeat (3) @(posedge clock);
                #1 bus.flush = 1'b1;
                @(posedge clock);
                #1 bus.flush = 1'b0;
            end
        join
        do_req(32'h200, 0, 1'b0, mem_word(32'h200), 2, 1'b0);
        do_req(32'h000, 0, 1'b0, mem_word(32'h0), 1, 1'b0);

        // flush and request in the same IDLE cycle
        @(posedge clock);
        #1;
        bus.flush = 1'b1;
        fork
            do_req(32'h200, 0, 1'b0, mem_word(32'h200), 1, 1'b0);
            begin
                @(posedge clock);
                #1 bus.flush = 1'b0;
            end
        join

        // reset after two refill words of 0x300
        @(posedge clock);
        #1;
        mem_stall = 0;
        mem_q.push_back(32'h300);
        mem_q.push_back(32'h304);
        mem_q.push_back(32'h308);
        bus.icache_addr = 32'h300;
        bus.icache_req = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b0;
        bus.icache_req = 1'b0;
        @(posedge clock);
        #1;
        check("midfill_reset_mem_req", {31'h0, bus.mem_req}, 32'h0);
        check("midfill_reset_rdy", {31'h0, bus.icache_rdy}, 32'h0);
        reset = 1'b1;
        @(posedge clock);
        #1;
        do_req(32'h300, 0, 1'b0, mem_word(32'h300), 0, 1'b0);

        // request withdrawn mid-fill still completes and installs the line
        do_req(32'h400, 0, 1'b0, mem_word(32'h400), 1, 1'b1);
        repeat (3) @(posedge clock);
        #1;
        do_req(32'h404, 0, 1'b1, mem_word(32'h404), 0, 1'b0);

        repeat (3) @(posedge clock);
        #1;
        check("sb_drained", 32'(sb.size()), 32'h0);
        check("memq_drained", 32'(mem_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
